mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one external memory bus between the IF stage (instruction fetch) and the MEM stage (load/store).
//  Sequences each access as a request/ack transaction.
//  Raises per-stage stall requests toward the pipeline stall controller until that stage's access completes.
//  Sits between the pipeline stages and the SRAM/bus interface; contains no datapath logic.
// PARAMETERS
//  AW       32   address width (byte address)
//  DW       32   data width
//  TO_CYC   255  bus cycles to wait for bus_ack before aborting with error; counter width = $clog2(TO_CYC+1)
// PORTS
//  clk          in   1     rising-edge clock
//  rst          in   1     asynchronous reset, active-low (0 = reset)
//  flush        in   1     pipeline flush; discards any in-flight IF result
//  if_req       in   1     IF requests a fetch (level, held until if_ack)
//  if_addr      in   AW    fetch address
//  if_ack       out  1     one-cycle pulse: if_rdata valid
//  if_rdata     out  DW    fetched instruction
//  mem_req      in   1     MEM requests a load/store (level, held until mem_ack)
//  mem_we       in   1     1 = store, 0 = load
//  mem_addr     in   AW    load/store address
//  mem_sel      in   4     byte enables
//  mem_wdata    in   DW    store data
//  mem_ack      out  1     one-cycle pulse: access done, mem_rdata valid for loads
//  mem_rdata    out  DW    load data
//  bus_err      out  1     one-cycle pulse together with the ack of a timed-out access
//  stallreq_if  out  1     = if_req & ~if_ack  (combinational)
//  stallreq_mem out  1     = mem_req & ~mem_ack (combinational)
//  bus_req      out  1     bus cycle active (registered)
//  bus_we, bus_addr, bus_sel, bus_wdata  out  1/AW/4/DW  registered bus command
//  bus_ack      in   1     bus completes the current cycle (rdata valid this cycle)
//  bus_rdata    in   DW    bus read data
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; all outputs 0; timeout counter 0; flush-drop flag 0.
//  FSM: IDLE -> GRANT_MEM | GRANT_IF -> RESP -> IDLE.
//  IDLE
//   - mem_req=1: go GRANT_MEM. mem_req has fixed priority over if_req (older instruction wins).
//   - else if_req=1 and flush=0: go GRANT_IF.
//   - Bus command registers load on the transition edge, so bus_req rises 1 cycle after the grant decision.
//  GRANT_x
//   - bus_req=1; command held stable until bus_ack.
//   - bus_ack=1: capture bus_rdata into x_rdata; go RESP.
//   - Counter increments every GRANT cycle without ack. When it reaches TO_CYC: go RESP with rdata=0 and bus_err set.
//  RESP
//   - bus_req=0; x_ack=1 for exactly one cycle (bus_err with it if timed out); go IDLE.
//   - Read data stays valid in x_rdata until the next capture.
//  Latency: req in IDLE at cycle N, bus_ack at first opportunity (N+1) -> ack at N+2.
//   - Minimum 3 cycles per access including the IDLE turnaround.
//   - Back-to-back grants are always separated by one IDLE cycle.
//  Flush
//   - Asserted during GRANT_IF or RESP(IF): the bus cycle runs to completion (no mid-cycle abort), but if_ack is suppressed.
//   - if_req is re-evaluated only in IDLE after flush deasserts.
//   - flush has no effect on MEM transactions.
//  Simultaneous if_req & mem_req in IDLE: MEM granted; IF waits, stallreq_if stays high. No IF starvation concern (MEM stalls upstream).
//  Request withdrawn mid-transaction (non-flush): transaction completes, ack still pulses.
//  Stores: mem_rdata not updated (holds previous value).
//  Reset mid-transaction: bus_req drops immediately (async); no ack is issued.
// STRUCTURE
//  Shared defines header: FSM state encodings (2 bits), bus width constants, byte-select width.
//  Single module, no sub-module. Timeout counter and FSM live in one sequential block; stall/ack decode is combinational.
// TESTING
//  1. IF only, bus_ack 1 cycle after bus_req, rdata=0x3C010000 -> if_ack at N+2, if_rdata=0x3C010000, stallreq_if high N..N+1.
//  2. if_req & mem_req same cycle, mem load addr 0x100 -> bus_addr=0x100 first; mem_ack, then IDLE, then IF grant; if_ack 3 cycles after mem_ack.
//  3. Store mem_we=1, sel=4'b0011, wdata=0xDEADBEEF, ack after 4 wait cycles -> bus_we=1, bus_sel=0011; mem_ack after ack; mem_rdata unchanged.
//  4. flush one cycle during GRANT_IF -> bus cycle completes, no if_ack; next IF request served normally.
//  5. No bus_ack, TO_CYC=8 -> after 8 GRANT cycles: ack with bus_err=1, rdata=0; FSM back to IDLE.
//  6. rst=0 asserted mid GRANT_MEM -> bus_req=0, mem_ack=0 without a clock edge; after release, re-requested access completes.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter.
//   - FSM state encoding (2 bits)
//   - default bus address/data widths and byte-select width
package mem_bus_arbiter_pkg;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;
  localparam int SEL_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GRANT_MEM = 2'd1,
    ST_GRANT_IF  = 2'd2,
    ST_RESP      = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// External memory bus between the arbiter and the SRAM/bus interface.
//   master : arbiter side, drives the registered command (bus_req, bus_we,
//            bus_addr, bus_sel, bus_wdata) and receives bus_ack/bus_rdata
//   slave  : memory side, receives the command and returns bus_ack/bus_rdata
interface mem_bus_arbiter_if
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AW = BUS_AW,
  parameter int DW = BUS_DW
);

  logic             bus_req;
  logic             bus_we;
  logic [AW-1:0]    bus_addr;
  logic [SEL_W-1:0] bus_sel;
  logic [DW-1:0]    bus_wdata;
  logic             bus_ack;
  logic [DW-1:0]    bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    output bus_ack, bus_rdata
  );

endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory bus between instruction fetch (IF) and
// load/store (MEM). Each access is a request/ack transaction; MEM has fixed
// priority. Per-stage stall requests stay high until that stage's ack.
// Ports:
//   clk, rst (async, active-low)
//   flush                 : discard an in-flight IF result
//   if_req/if_addr        -> if_ack/if_rdata
//   mem_req/we/addr/sel/wdata -> mem_ack/mem_rdata
//   bus_err               : pulses with the ack of a timed-out access
//   stallreq_if/mem       : combinational stall requests
//   bus (master modport)  : registered bus command, bus_ack/bus_rdata back
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AW     = BUS_AW,
  parameter int DW     = BUS_DW,
  parameter int TO_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             if_req,
  input  logic [AW-1:0]    if_addr,
  output logic             if_ack,
  output logic [DW-1:0]    if_rdata,
  input  logic             mem_req,
  input  logic             mem_we,
  input  logic [AW-1:0]    mem_addr,
  input  logic [SEL_W-1:0] mem_sel,
  input  logic [DW-1:0]    mem_wdata,
  output logic             mem_ack,
  output logic [DW-1:0]    mem_rdata,
  output logic             bus_err,
  output logic             stallreq_if,
  output logic             stallreq_mem,
  mem_bus_arbiter_if.master bus
);

  localparam int              CNT_W    = $clog2(TO_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_CYC - 1);

  arb_state_e       state_q, state_d;
  logic             owner_mem_q, owner_mem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             drop_q, drop_d;
  logic             bus_req_q, bus_req_d;
  logic             bus_we_q, bus_we_d;
  logic [AW-1:0]    bus_addr_q, bus_addr_d;
  logic [SEL_W-1:0] bus_sel_q, bus_sel_d;
  logic [DW-1:0]    bus_wdata_q, bus_wdata_d;
  logic [DW-1:0]    if_rdata_q, if_rdata_d;
  logic [DW-1:0]    mem_rdata_q, mem_rdata_d;
  logic             cap_en;
  logic [DW-1:0]    cap_val;
  logic             resp_mem, resp_if;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      owner_mem_q <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      drop_q      <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_sel_q   <= '0;
      bus_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_mem_q <= owner_mem_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      drop_q      <= drop_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_sel_q   <= bus_sel_d;
      bus_wdata_q <= bus_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_mem_d = owner_mem_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    drop_d      = drop_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_sel_d   = bus_sel_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    cap_en      = 1'b0;
    cap_val     = '0;

    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        err_d  = 1'b0;
        drop_d = 1'b0;
        // The command registers load on the grant edge, so bus_req
        // appears one cycle after the decision.
        if (mem_req) begin
          state_d     = ST_GRANT_MEM;
          owner_mem_d = 1'b1;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we;
          bus_addr_d  = mem_addr;
          bus_sel_d   = mem_sel;
          bus_wdata_d = mem_wdata;
        end else if (if_req && !flush) begin
          state_d     = ST_GRANT_IF;
          owner_mem_d = 1'b0;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr;
          bus_sel_d   = '1;
          bus_wdata_d = '0;
        end
      end
      ST_GRANT_MEM, ST_GRANT_IF: begin
        // A flushed fetch still runs to completion; only its ack is dropped.
        if (state_q == ST_GRANT_IF && flush) drop_d = 1'b1;
        if (bus.bus_ack) begin
          state_d   = ST_RESP;
          bus_req_d = 1'b0;
          cnt_d     = '0;
          cap_en    = 1'b1;
          cap_val   = bus.bus_rdata;
        end else if (cnt_q == CNT_LAST) begin
          // TO_CYC grant cycles without ack: abort and return zero data.
          state_d   = ST_RESP;
          bus_req_d = 1'b0;
          cnt_d     = '0;
          err_d     = 1'b1;
          cap_en    = 1'b1;
          cap_val   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        err_d   = 1'b0;
        drop_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    // Stores leave mem_rdata holding the last load result.
    if (cap_en) begin
      if (owner_mem_q) begin
        if (!bus_we_q) mem_rdata_d = cap_val;
      end else begin
        if_rdata_d = cap_val;
      end
    end
  end

  assign resp_mem = (state_q == ST_RESP) && owner_mem_q;
  assign resp_if  = (state_q == ST_RESP) && !owner_mem_q && !drop_q && !flush;

  assign mem_ack      = resp_mem;
  assign if_ack       = resp_if;
  assign bus_err      = err_q && (resp_mem || resp_if);
  assign if_rdata     = if_rdata_q;
  assign mem_rdata    = mem_rdata_q;
  assign stallreq_if  = if_req && !if_ack;
  assign stallreq_mem = mem_req && !mem_ack;

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_sel   = bus_sel_q;
  assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a queue-based scoreboard.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_sel;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        bus_err;
  logic        stallreq_if;
  logic        stallreq_mem;

  mem_bus_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_bus_arbiter #(.AW(32), .DW(32), .TO_CYC(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_ack       (if_ack),
    .if_rdata     (if_rdata),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_sel      (mem_sel),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .bus_err      (bus_err),
    .stallreq_if  (stallreq_if),
    .stallreq_mem (stallreq_mem),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_mem;
    logic [31:0] rdata;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Bus responder: acks in grant cycle rsp_wait+1; rsp_wait < 0 never acks.
  int          rsp_wait = -1;
  logic [31:0] rsp_data = '0;
  int          gcnt     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit is_mem, input logic [31:0] rdata, input bit err, input int c);
    exp_t e;
    e.is_mem = is_mem;
    e.rdata  = rdata;
    e.err    = err;
    e.cyc    = c;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic wait_ack(input bit is_mem, input int budget);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    while (n < budget && !seen) begin
      @(negedge clk);
      if (is_mem ? mem_ack : if_ack) seen = 1'b1;
      else n++;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_wait: no %s ack within %0d cycles", is_mem ? "mem" : "if", budget);
    end else begin
      check(is_mem ? "stallreq_mem_at_ack" : "stallreq_if_at_ack",
            {31'd0, is_mem ? stallreq_mem : stallreq_if}, 32'd0);
    end
    step();
  endtask

  initial begin
    bus.bus_ack   = 1'b0;
    bus.bus_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.bus_req) begin
        gcnt++;
        if (rsp_wait >= 0 && gcnt == rsp_wait + 1) begin
          bus.bus_ack   = 1'b1;
          bus.bus_rdata = rsp_data;
        end else begin
          bus.bus_ack   = 1'b0;
          bus.bus_rdata = 32'hBAD0BAD0;
        end
      end else begin
        gcnt          = 0;
        bus.bus_ack   = 1'b0;
        bus.bus_rdata = 32'hBAD0BAD0;
      end
    end
  end

  // Scoreboard monitor: every ack must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst && (if_ack || mem_ack)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: if_ack=%0b mem_ack=%0b with nothing expected (cycle %0d)",
                 if_ack, mem_ack, cyc);
      end else begin
        e = exp_q.pop_front();
        check("ack_kind", {31'd0, mem_ack}, {31'd0, e.is_mem});
        check("ack_cycle", 32'(cyc), 32'(e.cyc));
        check("ack_rdata", e.is_mem ? mem_rdata : if_rdata, e.rdata);
        check("ack_err", {31'd0, bus_err}, {31'd0, e.err});
      end
    end else if (bus_err) begin
      check("err_without_ack", {31'd0, bus_err}, 32'd0);
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst       = 1'b0;
    flush     = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_sel   = '0;
    mem_wdata = '0;

    repeat (3) step();
    neg();
    check("rst_bus_req", {31'd0, bus.bus_req}, 32'd0);
    check("rst_acks", {30'd0, if_ack, mem_ack}, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_bus_addr", bus.bus_addr, 32'd0);
    step();
    rst = 1'b1;
    step();

    // 1: single fetch, ack in first grant cycle
    step();
    rsp_wait = 0; rsp_data = 32'h3C010000;
    if_addr = 32'h400; if_req = 1'b1;
    n = cyc;
    push(1'b0, 32'h3C010000, 1'b0, n + 2);
    neg();
    check("t1_stall_if_N", {31'd0, stallreq_if}, 32'd1);
    check("t1_bus_req_N", {31'd0, bus.bus_req}, 32'd0);
    step(); neg();
    check("t1_bus_req_N1", {31'd0, bus.bus_req}, 32'd1);
    check("t1_bus_addr", bus.bus_addr, 32'h400);
    check("t1_stall_if_N1", {31'd0, stallreq_if}, 32'd1);
    wait_ack(1'b0, 20);
    if_req = 1'b0;

    // 2: simultaneous requests, MEM first, IF three cycles after mem_ack
    step();
    rsp_wait = 0; rsp_data = 32'h11112222;
    mem_we = 1'b0; mem_addr = 32'h100; mem_sel = 4'hF; mem_req = 1'b1;
    if_addr = 32'h200; if_req = 1'b1;
    n = cyc;
    push(1'b1, 32'h11112222, 1'b0, n + 2);
    push(1'b0, 32'h33334444, 1'b0, n + 5);
    neg();
    check("t2_stall_mem", {31'd0, stallreq_mem}, 32'd1);
    check("t2_stall_if", {31'd0, stallreq_if}, 32'd1);
    step(); neg();
    check("t2_bus_addr_mem", bus.bus_addr, 32'h100);
    check("t2_bus_we_mem", {31'd0, bus.bus_we}, 32'd0);
    wait_ack(1'b1, 20);
    mem_req = 1'b0; rsp_data = 32'h33334444;
    neg();
    check("t2_idle_gap", {31'd0, bus.bus_req}, 32'd0);
    check("t2_stall_if_wait", {31'd0, stallreq_if}, 32'd1);
    step(); neg();
    check("t2_bus_addr_if", bus.bus_addr, 32'h200);
    wait_ack(1'b0, 20);
    if_req = 1'b0;

    // 3: store with 4 wait cycles; mem_rdata keeps previous load value
    step();
    rsp_wait = 4; rsp_data = 32'hFFFF0000;
    mem_we = 1'b1; mem_sel = 4'b0011; mem_wdata = 32'hDEADBEEF;
    mem_addr = 32'h80; mem_req = 1'b1;
    n = cyc;
    push(1'b1, 32'h11112222, 1'b0, n + 6);
    step(); neg();
    check("t3_bus_we", {31'd0, bus.bus_we}, 32'd1);
    check("t3_bus_sel", {28'd0, bus.bus_sel}, 32'h3);
    check("t3_bus_wdata", bus.bus_wdata, 32'hDEADBEEF);
    check("t3_bus_addr", bus.bus_addr, 32'h80);
    step(); step(); neg();
    check("t3_bus_req_wait", {31'd0, bus.bus_req}, 32'd1);
    check("t3_stall_mem_wait", {31'd0, stallreq_mem}, 32'd1);
    check("t3_wdata_stable", bus.bus_wdata, 32'hDEADBEEF);
    wait_ack(1'b1, 20);
    mem_req = 1'b0; mem_we = 1'b0;

    // 4: flush during GRANT_IF drops the ack; next fetch served normally
    step();
    rsp_wait = 2; rsp_data = 32'h5555AAAA;
    if_addr = 32'h300; if_req = 1'b1;
    n = cyc;
    step();
    flush = 1'b1;
    neg();
    check("t4_bus_req_flush", {31'd0, bus.bus_req}, 32'd1);
    step();
    flush = 1'b0; if_addr = 32'h340;
    step(); neg();
    check("t4_bus_completes", {31'd0, bus.bus_req}, 32'd1);
    step();
    rsp_wait = 0; rsp_data = 32'h12345678;
    neg();
    check("t4_if_ack_dropped", {31'd0, if_ack}, 32'd0);
    check("t4_stall_if_held", {31'd0, stallreq_if}, 32'd1);
    check("t4_resp_bus_req", {31'd0, bus.bus_req}, 32'd0);
    step();
    push(1'b0, 32'h12345678, 1'b0, n + 7);
    neg();
    check("t4_idle_bus_req", {31'd0, bus.bus_req}, 32'd0);
    step(); neg();
    check("t4_refetch_addr", bus.bus_addr, 32'h340);
    wait_ack(1'b0, 20);
    if_req = 1'b0;

    // 5: no bus_ack -> timeout after 8 grant cycles
    step();
    rsp_wait = -1;
    mem_we = 1'b0; mem_addr = 32'h500; mem_sel = 4'hF; mem_req = 1'b1;
    n = cyc;
    push(1'b1, 32'h0, 1'b1, n + 9);
    repeat (8) step();
    neg();
    check("t5_bus_req_8th", {31'd0, bus.bus_req}, 32'd1);
    check("t5_no_early_ack", {31'd0, mem_ack}, 32'd0);
    wait_ack(1'b1, 20);
    mem_req = 1'b0;
    neg();
    check("t5_idle_bus_req", {31'd0, bus.bus_req}, 32'd0);
    check("t5_err_cleared", {31'd0, bus_err}, 32'd0);
    check("t5_rdata_zero", mem_rdata, 32'h0);

    // 6: async reset in GRANT_MEM, then the re-request completes
    step();
    mem_addr = 32'h600; mem_req = 1'b1;
    step(); step();
    #2;
    rst = 1'b0;
    #1;
    check("t6_async_bus_req", {31'd0, bus.bus_req}, 32'd0);
    check("t6_async_mem_ack", {31'd0, mem_ack}, 32'd0);
    check("t6_async_if_rdata", if_rdata, 32'd0);
    step(); step(); neg();
    check("t6_rst_mem_ack", {31'd0, mem_ack}, 32'd0);
    check("t6_rst_bus_req", {31'd0, bus.bus_req}, 32'd0);
    step();
    rst = 1'b1;
    rsp_wait = 0; rsp_data = 32'hCAFEF00D;
    n = cyc;
    push(1'b1, 32'hCAFEF00D, 1'b0, n + 2);
    wait_ack(1'b1, 20);
    mem_req = 1'b0;

    step(); step();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
